cim_row_ctrl: RTL and testbench

CIM_ROW_CTRL -- requirements
Module: cim_row_ctrl

---
 rtl/cim_row_ctrl_pkg.sv | 27 ++
 rtl/cim_row_ctrl_wl_decoder.sv | 22 ++
 rtl/cim_row_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cim_row_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_row_ctrl_pkg.sv
// Shared definitions for the CIM row controller, its array model and benches:
// FSM state encodings, command op encodings and default array geometry.
package cim_row_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WPULSE   = 3'd1,
        RECOVER  = 3'd2,
        SETTLE_S = 3'd3,
        RESP     = 3'd4
    } state_e;

    localparam logic OP_WRITE   = 1'b0;
    localparam logic OP_COMPUTE = 1'b1;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

    // Settle counter width; SETTLE is limited to 1..15 so SETTLE-1 fits.
    localparam int CNT_W = 4;

    // Counter load value for a given settle length.
    function automatic logic [CNT_W-1:0] settle_load(input int settle);
        return CNT_W'(settle - 1);
    endfunction

endpackage

// File: rtl/cim_row_ctrl_wl_decoder.sv
// One-hot word-line decoder with out-of-range detection. An out-of-range
// address produces an all-zero word-line vector, so the caller never has to
// mask it separately.
module wl_decoder #(
    parameter int ROWS   = 8,
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0] row_i,
    output logic [ROWS-1:0]   wl_o,
    output logic              oor_o
);

    // Compare each row index against the address; rows >= ROWS never match.
    always_comb begin
        wl_o  = '0;
        oor_o = (32'(row_i) >= 32'(ROWS));
        for (int r = 0; r < ROWS; r++) begin
            wl_o[r] = (32'(row_i) == 32'(r));
        end
    end

endmodule

// File: rtl/cim_row_ctrl.sv
// Row controller for a compute-in-memory array: accepts one write or compute
// command at a time, drives registered word/bit lines and compute controls,
// and returns compute results through a valid/ready response port.
module cim_row_ctrl
    import cim_row_ctrl_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int ADDR_W = 3,
    parameter int SETTLE = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_OP,
    input  logic [ADDR_W-1:0] CMD_ROW,
    input  logic [COLS-1:0]   CMD_DATA,
    input  logic              CMD_CI,
    output logic [ROWS-1:0]   WL,
    output logic [COLS-1:0]   BL,
    output logic              WE,
    output logic              CE,
    output logic [COLS-1:0]   INPUT,
    output logic              CI,
    input  logic [COLS-1:0]   ARR_OUT,
    input  logic              ARR_CO,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [COLS-1:0]   RES_DATA,
    output logic              RES_CO,
    output logic              RES_ERR
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [ROWS-1:0]    wl_q, wl_d;
    logic [COLS-1:0]    bl_q, bl_d;
    logic               we_q, we_d;
    logic               ce_q, ce_d;
    logic [COLS-1:0]    inp_q, inp_d;
    logic               ci_q, ci_d;
    logic               res_valid_q, res_valid_d;
    logic [COLS-1:0]    res_data_q, res_data_d;
    logic               res_co_q, res_co_d;
    logic               res_err_q, res_err_d;

    logic [ROWS-1:0]    dec_wl;
    logic               dec_oor;

    wl_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_wl_dec (
        .row_i (CMD_ROW),
        .wl_o  (dec_wl),
        .oor_o (dec_oor)
    );

    // Next-state and registered-output logic; every command field is used only
    // in IDLE on the accept edge, so later bus changes cannot leak through.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        wl_d        = wl_q;
        bl_d        = bl_q;
        we_d        = we_q;
        ce_d        = ce_q;
        inp_d       = inp_q;
        ci_d        = ci_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_co_d    = res_co_q;
        res_err_d   = res_err_q;

        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    // Out-of-range rows keep the normal timing but leave the
                    // array untouched (decoder already yields WL=0).
                    wl_d = dec_wl;
                    if (CMD_OP == OP_COMPUTE) begin
                        state_d = SETTLE_S;
                        ce_d    = !dec_oor;
                        inp_d   = dec_oor ? '0 : CMD_DATA;
                        ci_d    = dec_oor ? 1'b0 : CMD_CI;
                        cnt_d   = SETTLE_LOAD;
                        err_d   = dec_oor;
                    end else begin
                        state_d = WPULSE;
                        we_d    = !dec_oor;
                        bl_d    = dec_oor ? '0 : CMD_DATA;
                    end
                end
            end
            WPULSE: begin
                state_d = RECOVER;
                wl_d    = '0;
                bl_d    = '0;
                we_d    = 1'b0;
            end
            RECOVER: begin
                state_d = IDLE;
            end
            SETTLE_S: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_data_d  = err_q ? '0 : ARR_OUT;
                    res_co_d    = err_q ? 1'b0 : ARR_CO;
                    res_err_d   = err_q;
                    wl_d        = '0;
                    ce_d        = 1'b0;
                    inp_d       = '0;
                    ci_d        = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (RES_READY) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the array controls at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            wl_q        <= '0;
            bl_q        <= '0;
            we_q        <= 1'b0;
            ce_q        <= 1'b0;
            inp_q       <= '0;
            ci_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_co_q    <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            wl_q        <= wl_d;
            bl_q        <= bl_d;
            we_q        <= we_d;
            ce_q        <= ce_d;
            inp_q       <= inp_d;
            ci_q        <= ci_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_co_q    <= res_co_d;
            res_err_q   <= res_err_d;
        end
    end

    assign CMD_READY = (state_q == IDLE);
    assign WL        = wl_q;
    assign BL        = bl_q;
    assign WE        = we_q;
    assign CE        = ce_q;
    assign INPUT     = inp_q;
    assign CI        = ci_q;
    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;
    assign RES_CO    = res_co_q;
    assign RES_ERR   = res_err_q;

endmodule

// File: tb/tb_cim_row_ctrl.sv
// Bench for cim_row_ctrl: directed write/compute/back-pressure/out-of-range/
// reset scenarios, then back-to-back random commands scored against a simple
// memory-plus-adder reference of the array behaviour.
module tb_cim_row_ctrl;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int ADDR_W = 4;
    localparam int SETTLE = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              CMD_VALID = 1'b0;
    logic              CMD_READY;
    logic              CMD_OP = 1'b0;
    logic [ADDR_W-1:0] CMD_ROW = '0;
    logic [COLS-1:0]   CMD_DATA = '0;
    logic              CMD_CI = 1'b0;
    logic [ROWS-1:0]   WL;
    logic [COLS-1:0]   BL;
    logic              WE;
    logic              CE;
    logic [COLS-1:0]   INPUT;
    logic              CI;
    logic [COLS-1:0]   ARR_OUT;
    logic              ARR_CO;
    logic              RES_VALID;
    logic              RES_READY = 1'b0;
    logic [COLS-1:0]   RES_DATA;
    logic              RES_CO;
    logic              RES_ERR;

    int checks   = 0;
    int failures = 0;

    cim_row_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .SETTLE(SETTLE)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_ROW(CMD_ROW), .CMD_DATA(CMD_DATA), .CMD_CI(CMD_CI),
        .WL(WL), .BL(BL), .WE(WE), .CE(CE), .INPUT(INPUT), .CI(CI),
        .ARR_OUT(ARR_OUT), .ARR_CO(ARR_CO),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_CO(RES_CO), .RES_ERR(RES_ERR)
    );

    always #5 CLK = ~CLK;

    // Array stand-in: rows written on WE, compute = selected row + INPUT + CI.
    logic [COLS-1:0] arr_mem [ROWS];
    logic            ovr_en  = 1'b0;
    logic [COLS-1:0] ovr_out = '0;
    logic            ovr_co  = 1'b0;

    initial for (int r = 0; r < ROWS; r++) arr_mem[r] = '0;

    always @(posedge CLK) begin
        if (WE) for (int r = 0; r < ROWS; r++) if (WL[r]) arr_mem[r] <= BL;
    end

    always_comb begin
        logic [COLS-1:0] sel;
        sel = '0;
        for (int r = 0; r < ROWS; r++) if (WL[r]) sel = sel | arr_mem[r];
        if (ovr_en) {ARR_CO, ARR_OUT} = {ovr_co, ovr_out};
        else if (CE) {ARR_CO, ARR_OUT} = {1'b0, sel} + {1'b0, INPUT} + {8'd0, CI};
        else {ARR_CO, ARR_OUT} = '0;
    end

    // Reference: what each row holds, according to the commands issued.
    logic [COLS-1:0] ref_mem [ROWS];
    initial for (int r = 0; r < ROWS; r++) ref_mem[r] = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Safety properties every cycle.
    always @(negedge CLK) begin
        chk("wl_onehot0", 32'($onehot0(WL)), 32'd1);
        chk("we_ce_excl", 32'(WE && CE), 32'd0);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!CMD_READY && n < 50) begin
            step();
            n++;
        end
        chk("ready_timeout", 32'(CMD_READY), 32'd1);
    endtask

    function automatic logic [31:0] exp_onehot(input logic [ADDR_W-1:0] row);
        return (32'(row) < ROWS) ? (32'd1 << row) : 32'd0;
    endfunction

    // Expected {err, co, data} for a compute command.
    function automatic logic [31:0] exp_res(input logic [ADDR_W-1:0] row,
                                            input logic [COLS-1:0] op, input logic ci);
        logic [31:0] sum;
        if (32'(row) >= ROWS) return 32'h200;
        sum = 32'(ref_mem[row[2:0]]) + 32'(op) + 32'(ci);
        return {22'd0, 1'b0, sum[8:0]};
    endfunction

    // Offer a command, let it be accepted on the next edge; afterwards the bus
    // is either scrambled (valid dropped) or left valid with junk fields.
    task automatic issue(input logic op, input logic [ADDR_W-1:0] row,
                         input logic [COLS-1:0] data, input logic ci, input logic keep);
        wait_ready();
        CMD_VALID = 1'b1; CMD_OP = op; CMD_ROW = row; CMD_DATA = data; CMD_CI = ci;
        step();
        if (!op && 32'(row) < ROWS) ref_mem[row[2:0]] = data;
        CMD_VALID = keep;
        CMD_OP = 1'($urandom); CMD_ROW = ADDR_W'($urandom);
        CMD_DATA = COLS'($urandom); CMD_CI = 1'($urandom);
    endtask

    task automatic wait_res(output int lat);
        lat = 1;
        while (!RES_VALID && lat < 30) begin
            step();
            lat++;
        end
        chk("res_timeout", 32'(RES_VALID), 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] er;

        // Reset state.
        step(); step();
        chk("rst_ready", 32'(CMD_READY), 32'd1);
        chk("rst_outs", {WL, BL, INPUT, 8'd0} , 32'd0);
        chk("rst_ctl", {27'd0, WE, CE, CI, RES_VALID, RES_CO}, 32'd0);
        chk("rst_res", {23'd0, RES_DATA, RES_ERR}, 32'd0);
        RST = 1'b0;
        step();

        // Write row 3 = A5: one pulse, then idle again three cycles after accept.
        issue(1'b0, 4'd3, 8'hA5, 1'b0, 1'b0);
        chk("wr_pulse_we", 32'(WE), 32'd1);
        chk("wr_pulse_wl", 32'(WL), 32'h08);
        chk("wr_pulse_bl", 32'(BL), 32'hA5);
        chk("wr_pulse_rdy", 32'(CMD_READY), 32'd0);
        step();
        chk("wr_rec_lines", {8'd0, WL, BL, 7'd0, WE}, 32'd0);
        chk("wr_rec_rdy", 32'(CMD_READY), 32'd0);
        step();
        chk("wr_idle_rdy", 32'(CMD_READY), 32'd1);

        // Compute row 3, operand 0F, CI=1 with a forced array answer 5A/1.
        ovr_en = 1'b1; ovr_out = 8'h5A; ovr_co = 1'b1;
        issue(1'b1, 4'd3, 8'h0F, 1'b1, 1'b0);
        chk("cmp_c1", {WL, INPUT, 6'd0, CE, CI, 7'd0, WE}, {8'h08, 8'h0F, 8'h03, 8'h00});
        step();
        chk("cmp_c2", {WL, INPUT, 6'd0, CE, CI, 7'd0, WE}, {8'h08, 8'h0F, 8'h03, 8'h00});
        step();
        chk("cmp_done_lines", {8'd0, WL, INPUT, 6'd0, CE, CI}, 32'd0);
        chk("cmp_res", {21'd0, RES_VALID, RES_ERR, RES_CO, RES_DATA}, {21'd0, 3'b101, 8'h5A});
        ovr_out = 8'h00; ovr_co = 1'b0;
        // Back-pressure: result held stable, no new command accepted.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", {20'd0, CMD_READY, RES_VALID, RES_ERR, RES_CO, RES_DATA},
                {20'd0, 4'b0101, 8'h5A});
        end
        RES_READY = 1'b1;
        step();
        chk("bp_release", {30'd0, RES_VALID, CMD_READY}, 32'd1);
        RES_READY = 1'b0;
        ovr_en = 1'b0;

        // Out-of-range row 9: no array activity; compute flags the error.
        issue(1'b0, 4'd9, 8'hFF, 1'b0, 1'b0);
        chk("oor_wr", {23'd0, WL, WE}, 32'd0);
        step(); step();
        chk("oor_wr_rdy", 32'(CMD_READY), 32'd1);
        issue(1'b1, 4'd9, 8'h33, 1'b1, 1'b0);
        chk("oor_cmp1", {23'd0, WL, CE}, 32'd0);
        step();
        chk("oor_cmp2", {23'd0, WL, CE}, 32'd0);
        step();
        chk("oor_res", {21'd0, RES_VALID, RES_ERR, RES_CO, RES_DATA}, {21'd0, 3'b110, 8'h00});
        RES_READY = 1'b1;
        step();
        RES_READY = 1'b0;

        // Reset asserted mid-settle drops the array controls without a clock.
        issue(1'b1, 4'd2, 8'h11, 1'b0, 1'b0);
        chk("rst_mid_pre", 32'(CE), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_async", {22'd0, WL, CE, RES_VALID}, 32'd0);
        chk("rst_mid_rdy", 32'(CMD_READY), 32'd1);
        step(); step();
        RST = 1'b0;
        step();
        issue(1'b0, 4'd5, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_wr", {15'd0, WE, WL, BL}, {15'd0, 1'b1, 8'h20, 8'h3C});
        step(); step();
        chk("post_rst_rdy", 32'(CMD_READY), 32'd1);

        // Back-to-back random commands with CMD_VALID held high.
        for (int i = 0; i < 60; i++) begin
            logic            op, ci, hold;
            logic [ADDR_W-1:0] row;
            logic [COLS-1:0] d;
            op   = 1'($urandom);
            row  = ADDR_W'($urandom_range(0, 11));
            d    = COLS'($urandom);
            ci   = 1'($urandom);
            hold = 1'($urandom);
            if (op) er = exp_res(row, d, ci);
            RES_READY = op && hold;
            issue(op, row, d, ci, 1'b1);
            if (!op) begin
                chk("rnd_wr", {15'd0, WE, WL, 8'd0},
                    {15'd0, 1'(32'(row) < ROWS), exp_onehot(row)[7:0], 8'd0});
            end else begin
                chk("rnd_cmp_ce", {23'd0, CE, WL},
                    {23'd0, 1'(32'(row) < ROWS), exp_onehot(row)[7:0]});
                wait_res(lat);
                chk("rnd_lat", 32'(lat), 32'(SETTLE + 1));
                chk("rnd_res", {22'd0, RES_ERR, RES_CO, RES_DATA}, er);
                if (!hold) begin
                    repeat ($urandom_range(0, 3)) begin
                        step();
                        chk("rnd_stable", {21'd0, CMD_READY, RES_VALID, RES_ERR, RES_CO, RES_DATA},
                            {21'd0, 1'b0, 1'b1, er[9:0]});
                    end
                    RES_READY = 1'b1;
                end
                step();
                chk("rnd_pulse", {30'd0, RES_VALID, CMD_READY}, 32'd1);
                RES_READY = 1'b0;
            end
        end
        CMD_VALID = 1'b0;
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
